draw_robot: RTL and testbench

DRAW_ROBOT -- requirements
Module: draw_robot

---
 rtl/robot_pkg.sv | 56 +++++
 rtl/vga_if.sv | 15 +
 rtl/robot_ctrl.sv | 115 +++++++++++
 rtl/draw_robot.sv | 107 ++++++++++
 tb/tb_draw_robot.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/robot_pkg.sv
// Shared types, geometry and colours for the robot overlay.
package robot_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned EXT_W     = COORD_W + 1;
  localparam int unsigned RGB_W     = 12;
  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned ZAP_CNT_W = 8;

  localparam int unsigned ROBOT_W = 32;
  localparam int unsigned ROBOT_H = 48;

  localparam int unsigned COL_OFF_W = 5;
  localparam int unsigned ROW_OFF_W = 6;

  localparam int unsigned EYE_ROW_LO = 8;
  localparam int unsigned EYE_ROW_HI = 11;
  localparam int unsigned EYE_L_LO   = 6;
  localparam int unsigned EYE_L_HI   = 11;
  localparam int unsigned EYE_R_LO   = 20;
  localparam int unsigned EYE_R_HI   = 25;

  localparam logic [RGB_W-1:0] COL_BODY = 12'h888;
  localparam logic [RGB_W-1:0] COL_EYE  = 12'hF00;
  localparam logic [RGB_W-1:0] COL_ZAP  = 12'hFF0;

  typedef enum logic [1:0] {
    MOVE_RIGHT = 2'd0,
    MOVE_LEFT  = 2'd1,
    ZAPPED     = 2'd2
  } state_t;

  // One pixel of the VGA stream as carried through the pipeline.
  typedef struct packed {
    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [RGB_W-1:0]   rgb;
  } vga_sig_t;

  // True when a box-relative offset lands on one of the two eyes.
  function automatic logic is_eye(input logic [ROW_OFF_W-1:0] row,
                                  input logic [COL_OFF_W-1:0] col);
    logic row_hit;
    logic left_hit;
    logic right_hit;
    row_hit   = (row >= ROW_OFF_W'(EYE_ROW_LO)) && (row <= ROW_OFF_W'(EYE_ROW_HI));
    left_hit  = (col >= COL_OFF_W'(EYE_L_LO)) && (col <= COL_OFF_W'(EYE_L_HI));
    right_hit = (col >= COL_OFF_W'(EYE_R_LO)) && (col <= COL_OFF_W'(EYE_R_HI));
    return row_hit && (left_hit || right_hit);
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour stream bundle passed between drawing stages.
interface vga_if;
  import robot_pkg::*;

  logic [COORD_W-1:0] vcount;
  logic               vsync;
  logic               vblnk;
  logic [COORD_W-1:0] hcount;
  logic               hsync;
  logic               hblnk;
  logic [RGB_W-1:0]   rgb;

  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/robot_ctrl.sv
// Per-frame robot behaviour: frame tick, zap capture, movement FSM and score.
module robot_ctrl
  import robot_pkg::*;
#(
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 800,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned ZAP_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblnk,
  input  logic               zap,
  output logic [COORD_W-1:0] robot_x,
  output logic               zapped,
  output logic               zap_hide,
  output logic [SCORE_W-1:0] score
);

  localparam logic [COORD_W-1:0] X_MIN_C = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_END_C = COORD_W'(X_MAX - ROBOT_W);
  localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);

  state_t               state;
  logic                 vblnk_q;
  logic                 armed;
  logic                 zap_pending;
  logic [ZAP_CNT_W-1:0] zap_cnt;
  logic                 frame_tick;
  logic                 zap_ok;
  logic [EXT_W-1:0]     x_ext;
  logic [EXT_W-1:0]     right_edge;

  // armed masks the first sample after reset so a vblnk already high is not an edge.
  assign frame_tick = armed & vblnk & ~vblnk_q;
  // Zaps arriving while already zapped are dropped outright.
  assign zap_ok     = zap & (state != ZAPPED);
  assign x_ext      = EXT_W'(robot_x);
  assign right_edge = x_ext + EXT_W'(SPEED + ROBOT_W);
  assign zap_hide   = zap_cnt[2];

  // vblnk rising-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
      armed   <= 1'b1;
    end
  end

  // Sticky zap request; a zap coincident with a tick is kept for the next tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zap_pending <= 1'b0;
    end else if (frame_tick) begin
      zap_pending <= zap_ok;
    end else if (zap_ok) begin
      zap_pending <= 1'b1;
    end
  end

  // Movement / zap FSM, advanced once per frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= MOVE_RIGHT;
      robot_x <= X_MIN_C;
      zap_cnt <= '0;
      score   <= '0;
      zapped  <= 1'b0;
    end else if (frame_tick) begin
      case (state)
        MOVE_RIGHT, MOVE_LEFT: begin
          if (zap_pending) begin
            state   <= ZAPPED;
            zapped  <= 1'b1;
            zap_cnt <= ZAP_CNT_W'(ZAP_FRAMES - 1);
            if (score != '1) begin
              score <= score + SCORE_W'(1);
            end
          end else if (state == MOVE_RIGHT) begin
            if (right_edge >= EXT_W'(X_MAX)) begin
              robot_x <= X_END_C;
              state   <= MOVE_LEFT;
            end else begin
              robot_x <= robot_x + SPEED_C;
            end
          end else begin
            if (x_ext < EXT_W'(X_MIN + SPEED)) begin
              robot_x <= X_MIN_C;
              state   <= MOVE_RIGHT;
            end else begin
              robot_x <= robot_x - SPEED_C;
            end
          end
        end
        ZAPPED: begin
          if (zap_cnt == '0) begin
            robot_x <= X_MIN_C;
            state   <= MOVE_RIGHT;
            zapped  <= 1'b0;
          end else begin
            zap_cnt <= zap_cnt - ZAP_CNT_W'(1);
          end
        end
        default: begin
          state  <= MOVE_RIGHT;
          zapped <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/draw_robot.sv
// Overlays the robot sprite on the VGA stream through a 2-stage pipeline.
module draw_robot
  import robot_pkg::*;
#(
  parameter int unsigned X_MIN      = 0,
  parameter int unsigned X_MAX      = 800,
  parameter int unsigned Y_POS      = 500,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned ZAP_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  vga_if.slave               vga_in,
  vga_if.master              vga_out,
  input  logic               zap,
  output logic [COORD_W-1:0] robot_x,
  output logic               zapped,
  output logic [SCORE_W-1:0] score
);

  logic                 zap_hide;
  vga_sig_t             s1;
  vga_sig_t             s2;
  logic                 s1_draw;
  logic [RGB_W-1:0]     s1_col;
  logic [EXT_W-1:0]     h_ext;
  logic [EXT_W-1:0]     v_ext;
  logic [EXT_W-1:0]     x_ext;
  logic                 in_x;
  logic                 in_y;
  logic [COL_OFF_W-1:0] col_off;
  logic [ROW_OFF_W-1:0] row_off;
  logic                 draw_c;
  logic [RGB_W-1:0]     col_c;

  robot_ctrl #(
    .X_MIN      (X_MIN),
    .X_MAX      (X_MAX),
    .SPEED      (SPEED),
    .ZAP_FRAMES (ZAP_FRAMES)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .vblnk    (vga_in.vblnk),
    .zap      (zap),
    .robot_x  (robot_x),
    .zapped   (zapped),
    .zap_hide (zap_hide),
    .score    (score)
  );

  // Hit test and sprite colour for the incoming pixel.
  always_comb begin
    h_ext   = EXT_W'(vga_in.hcount);
    v_ext   = EXT_W'(vga_in.vcount);
    x_ext   = EXT_W'(robot_x);
    in_x    = (h_ext >= x_ext) && (h_ext < x_ext + EXT_W'(ROBOT_W));
    in_y    = (v_ext >= EXT_W'(Y_POS)) && (v_ext < EXT_W'(Y_POS + ROBOT_H));
    col_off = COL_OFF_W'(vga_in.hcount - robot_x);
    row_off = ROW_OFF_W'(vga_in.vcount - COORD_W'(Y_POS));
    draw_c  = in_x && in_y && !vga_in.hblnk && !vga_in.vblnk && !(zapped && zap_hide);
    col_c   = COL_BODY;
    if (zapped) begin
      col_c = COL_ZAP;
    end else if (is_eye(row_off, col_off)) begin
      col_c = COL_EYE;
    end
  end

  // Stage 1: capture the stream and the draw decision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      s1_draw <= 1'b0;
      s1_col  <= '0;
    end else begin
      s1.vcount <= vga_in.vcount;
      s1.vsync  <= vga_in.vsync;
      s1.vblnk  <= vga_in.vblnk;
      s1.hcount <= vga_in.hcount;
      s1.hsync  <= vga_in.hsync;
      s1.hblnk  <= vga_in.hblnk;
      s1.rgb    <= vga_in.rgb;
      s1_draw   <= draw_c;
      s1_col    <= col_c;
    end
  end

  // Stage 2: merge sprite colour into the delayed stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2 <= '0;
    end else begin
      s2     <= s1;
      s2.rgb <= s1_draw ? s1_col : s1.rgb;
    end
  end

  assign vga_out.vcount = s2.vcount;
  assign vga_out.vsync  = s2.vsync;
  assign vga_out.vblnk  = s2.vblnk;
  assign vga_out.hcount = s2.hcount;
  assign vga_out.hsync  = s2.hsync;
  assign vga_out.hblnk  = s2.hblnk;
  assign vga_out.rgb    = s2.rgb;

endmodule

// File: tb/tb_draw_robot.sv
// Directed self-checking bench for draw_robot.
module tb_draw_robot;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        zap = 1'b0;
  logic [10:0] robot_x;
  logic        zapped;
  logic [7:0]  score;

  int n_cmp = 0;
  int n_err = 0;

  vga_if vin ();
  vga_if vout ();

  draw_robot dut (
    .clk     (clk),
    .rst     (rst),
    .vga_in  (vin),
    .vga_out (vout),
    .zap     (zap),
    .robot_x (robot_x),
    .zapped  (zapped),
    .score   (score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame boundary: vblnk low, rises (tick), falls.
  task automatic tick();
    vin.vblnk = 1'b0;
    step();
    vin.vblnk = 1'b1;
    step();
    vin.vblnk = 1'b0;
    step();
  endtask

  task automatic zap_pulse();
    zap = 1'b1;
    step();
    zap = 1'b0;
    step();
  endtask

  // Single pixel through the pipeline, background colour 12'h123.
  task automatic pix(input string tag, input int h, input int v, input logic hb,
                     input logic [11:0] exp);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.rgb    = 12'h123;
    step();
    step();
    chk(tag, 64'(vout.rgb), 64'(exp));
  endtask

  logic [37:0] prev;
  logic [37:0] cur;
  logic [37:0] outv;

  initial begin
    vin.vcount = '0; vin.vsync = 1'b0; vin.vblnk = 1'b0;
    vin.hcount = '0; vin.hsync = 1'b1; vin.hblnk = 1'b0;
    vin.rgb    = 12'h123;

    // Reset state
    step();
    step();
    chk("rst_robot_x", 64'(robot_x), 64'd0);
    chk("rst_zapped", 64'(zapped), 64'd0);
    chk("rst_score", 64'(score), 64'd0);
    outv = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
    chk("rst_vout", 64'(outv), 64'd0);

    // Release reset with vblnk already high: no tick
    vin.vblnk = 1'b1;
    rst = 1'b1;
    step(); step(); step();
    chk("no_false_tick", 64'(robot_x), 64'd0);
    vin.vblnk = 1'b0;
    step();

    // Five frames moving right
    chk("frame1_x", 64'(robot_x), 64'd0);
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("frame_x", 64'(robot_x), 64'(4 * k));
    end

    // Sprite pixels at robot_x = 16, Y_POS = 500
    pix("px_corner", 16, 500, 1'b0, 12'h888);
    pix("px_eyeL_tl", 22, 508, 1'b0, 12'hF00);
    pix("px_eyeL_br", 27, 511, 1'b0, 12'hF00);
    pix("px_between", 28, 508, 1'b0, 12'h888);
    pix("px_eyeR_l", 36, 510, 1'b0, 12'hF00);
    pix("px_eyeR_r", 41, 508, 1'b0, 12'hF00);
    pix("px_past_eye", 42, 508, 1'b0, 12'h888);
    pix("px_row_below_eye", 22, 512, 1'b0, 12'h888);
    pix("px_br_corner", 47, 547, 1'b0, 12'h888);
    pix("px_right_out", 48, 547, 1'b0, 12'h123);
    pix("px_left_out", 15, 500, 1'b0, 12'h123);
    pix("px_below_out", 16, 548, 1'b0, 12'h123);
    pix("px_above_out", 16, 499, 1'b0, 12'h123);
    pix("px_hblnk", 20, 520, 1'b1, 12'h123);
    vin.hblnk = 1'b0;

    // Right wall turnaround
    repeat (187) tick();
    chk("x_764", 64'(robot_x), 64'd764);
    tick();
    chk("x_wall", 64'(robot_x), 64'd768);
    tick();
    chk("x_back_left", 64'(robot_x), 64'd764);

    // Zap mid-frame
    zap_pulse();
    chk("zap_not_yet", 64'(zapped), 64'd0);
    tick();
    chk("zapped_in", 64'(zapped), 64'd1);
    chk("zap_score1", 64'(score), 64'd1);
    chk("zap_x_held", 64'(robot_x), 64'd764);
    pix("px_zap_hidden", 770, 520, 1'b0, 12'h123);
    zap_pulse();
    tick();
    tick();
    chk("zap_ignored", 64'(score), 64'd1);
    pix("px_zap_yellow", 770, 520, 1'b0, 12'hFF0);
    repeat (27) tick();
    chk("zap_29_ticks", 64'(zapped), 64'd1);
    chk("zap_29_x", 64'(robot_x), 64'd764);
    tick();
    chk("zap_exit", 64'(zapped), 64'd0);
    chk("zap_exit_x", 64'(robot_x), 64'd0);
    tick();
    chk("after_zap_right", 64'(robot_x), 64'd4);

    // Zap coincident with tick is deferred one frame
    vin.vblnk = 1'b0;
    step();
    vin.vblnk = 1'b1;
    zap = 1'b1;
    step();
    zap = 1'b0;
    vin.vblnk = 1'b0;
    step();
    chk("coinc_not_zapped", 64'(zapped), 64'd0);
    chk("coinc_moved", 64'(robot_x), 64'd8);
    tick();
    chk("coinc_zapped", 64'(zapped), 64'd1);
    chk("coinc_score", 64'(score), 64'd2);
    chk("coinc_x_held", 64'(robot_x), 64'd8);
    repeat (30) tick();

    // Build score up to 5
    for (int r = 0; r < 2; r++) begin
      zap_pulse();
      tick();
      repeat (30) tick();
    end
    chk("score4", 64'(score), 64'd4);
    zap_pulse();
    tick();
    chk("score5", 64'(score), 64'd5);
    chk("score5_zapped", 64'(zapped), 64'd1);

    // Async reset mid-ZAPPED
    #2;
    rst = 1'b0;
    #1;
    chk("arst_x", 64'(robot_x), 64'd0);
    chk("arst_zapped", 64'(zapped), 64'd0);
    chk("arst_score", 64'(score), 64'd0);
    outv = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
    chk("arst_vout", 64'(outv), 64'd0);
    vin.vblnk = 1'b1;
    step();
    rst = 1'b1;
    step(); step(); step();
    chk("arst_no_tick", 64'(robot_x), 64'd0);
    tick();
    chk("arst_move_right", 64'(robot_x), 64'd4);
    chk("arst_still_clear", 64'(zapped), 64'd0);

    // Stream off-sprite passes through delayed by 2 cycles
    prev = '0;
    for (int i = 0; i < 12; i++) begin
      vin.vcount = 11'(i * 13);
      vin.vsync  = i[0];
      vin.vblnk  = i[1];
      vin.hcount = 11'(i * 37 + 5);
      vin.hsync  = i[2];
      vin.hblnk  = i[3];
      vin.rgb    = 12'(i * 291 + 7);
      cur = {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk, vin.rgb};
      step();
      if (i >= 1) begin
        outv = {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
        chk("stream", 64'(outv), 64'(prev));
      end
      prev = cur;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
